// File: rtl/wt_dcache_drrip_ctrl.sv
// DRRIP policy controller and update sequencer for the dcache SRRIP replacement array.
// Define DRRIP_SET_DUEL_EN to enable set dueling (PSEL + BRRIP throttle); otherwise pure SRRIP insertion.
module wt_dcache_drrip_ctrl #(
    parameter int IDX_W      = 8,
    parameter int WAY_W      = 2,
    parameter int HITQ_DEPTH = 4,
    parameter int PSEL_W     = 10,
    parameter int BIP_W      = 5,
    parameter int LEADER_W   = 6
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             flush_i,
    input  logic             hit_req_i,
    input  logic [IDX_W-1:0] hit_idx_i,
    input  logic [WAY_W-1:0] hit_way_i,
    input  logic             miss_req_i,
    input  logic [IDX_W-1:0] miss_idx_i,
    input  logic [WAY_W-1:0] srrip_way_i,
    output logic             srrip_hit_o,
    output logic [IDX_W-1:0] srrip_hit_idx_o,
    output logic [WAY_W-1:0] srrip_hit_way_o,
    output logic             srrip_miss_o,
    output logic [IDX_W-1:0] srrip_miss_idx_o,
    output logic [1:0]       pred_result_o,
    output logic             hit_drop_o,
    output logic             policy_o,
    output logic [PSEL_W-1:0] psel_o
);
    localparam int AW = $clog2(HITQ_DEPTH);
    localparam int PW = AW + 1;
    localparam logic [PSEL_W-1:0] PSEL_INIT = {1'b1, {(PSEL_W-1){1'b0}}};

    logic [IDX_W-1:0]      q_idx [HITQ_DEPTH];
    logic [WAY_W-1:0]      q_way [HITQ_DEPTH];
    logic [HITQ_DEPTH-1:0] q_valid_reg, q_valid_next;
    logic [PW-1:0]         wr_ptr_reg, rd_ptr_reg;
    logic [AW-1:0]         wr_addr, rd_addr;
    logic                  empty, full, head_valid, bypass, pop, push, collide, hit_live;
    logic [HITQ_DEPTH-1:0] squash;

    assign wr_addr    = wr_ptr_reg[AW-1:0];
    assign rd_addr    = rd_ptr_reg[AW-1:0];
    assign empty      = (wr_ptr_reg == rd_ptr_reg);
    assign full       = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) && (wr_addr == rd_addr);
    assign head_valid = q_valid_reg[rd_addr];
    assign bypass     = empty && !miss_req_i;

    // A squashed head is only skipped once its valid bit has been cleared, so misses can retire it too.
    assign pop      = !flush_i && !empty && (!miss_req_i || !head_valid);
    assign collide  = miss_req_i && (hit_idx_i == miss_idx_i) && (hit_way_i == srrip_way_i);
    assign hit_live = !flush_i && hit_req_i && !bypass && !collide;
    assign push     = hit_live && (!full || pop);

    assign hit_drop_o      = hit_live && full && !pop;
    assign srrip_hit_o     = !flush_i && !miss_req_i && (empty ? hit_req_i : head_valid);
    assign srrip_hit_idx_o = empty ? hit_idx_i : q_idx[rd_addr];
    assign srrip_hit_way_o = empty ? hit_way_i : q_way[rd_addr];
    assign srrip_miss_o     = miss_req_i && !flush_i;
    assign srrip_miss_idx_o = miss_idx_i;

    for (genvar gi = 0; gi < HITQ_DEPTH; gi++) begin : g_entry
        assign squash[gi] = miss_req_i && q_valid_reg[gi] &&
                            (q_idx[gi] == miss_idx_i) && (q_way[gi] == srrip_way_i);
        assign q_valid_next[gi] = flush_i ? 1'b0 :
                                  (push && (wr_addr == AW'(gi))) ? 1'b1 :
                                  (q_valid_reg[gi] && !squash[gi]);
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            q_idx[wr_addr] <= hit_idx_i;
            q_way[wr_addr] <= hit_way_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_reg  <= '0;
            rd_ptr_reg  <= '0;
            q_valid_reg <= '0;
        end else begin
            q_valid_reg <= q_valid_next;
            if (flush_i) begin
                wr_ptr_reg <= '0;
                rd_ptr_reg <= '0;
            end else begin
                wr_ptr_reg <= wr_ptr_reg + PW'(push);
                rd_ptr_reg <= rd_ptr_reg + PW'(pop);
            end
        end
    end

`ifdef DRRIP_SET_DUEL_EN
    logic [PSEL_W-1:0] psel_reg, psel_next;
    logic [BIP_W-1:0]  bip_reg, bip_next;
    logic              srrip_leader, brrip_leader, brrip_type;

    assign srrip_leader  = (miss_idx_i[LEADER_W-1:0] == '0);
    assign brrip_leader  = (miss_idx_i[LEADER_W-1:0] == '1);
    assign policy_o      = psel_reg[PSEL_W-1];
    assign psel_o        = psel_reg;
    assign brrip_type    = brrip_leader || (!srrip_leader && policy_o);
    assign pred_result_o = (brrip_type && (bip_reg != '0)) ? 2'd0 : 2'd2;

    always_comb begin
        psel_next = psel_reg;
        bip_next  = bip_reg;
        if (flush_i) begin
            psel_next = PSEL_INIT;
            bip_next  = '0;
        end else if (miss_req_i) begin
            if (brrip_type)
                bip_next = bip_reg + 1'b1;
            if (srrip_leader && (psel_reg != '1))
                psel_next = psel_reg + 1'b1;
            else if (brrip_leader && (psel_reg != '0))
                psel_next = psel_reg - 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            psel_reg <= PSEL_INIT;
            bip_reg  <= '0;
        end else begin
            psel_reg <= psel_next;
            bip_reg  <= bip_next;
        end
    end
`else
    assign psel_o        = PSEL_INIT;
    assign policy_o      = 1'b0;
    assign pred_result_o = 2'd2;
`endif

endmodule

// File: tb/tb_wt_dcache_drrip_ctrl.sv
// Self-checking bench for wt_dcache_drrip_ctrl: directed steps plus random traffic against a queue-based model.
module tb_wt_dcache_drrip_ctrl;
`ifdef DRRIP_SET_DUEL_EN
    localparam bit DUEL = 1'b1;
`else
    localparam bit DUEL = 1'b0;
`endif
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst_ni = 1'b0;
    logic       flush_i = 1'b0;
    logic       hit_req_i = 1'b0;
    logic [7:0] hit_idx_i = '0;
    logic [1:0] hit_way_i = '0;
    logic       miss_req_i = 1'b0;
    logic [7:0] miss_idx_i = '0;
    logic [1:0] srrip_way_i = '0;
    logic       srrip_hit_o, srrip_miss_o, hit_drop_o, policy_o;
    logic [7:0] srrip_hit_idx_o, srrip_miss_idx_o;
    logic [1:0] srrip_hit_way_o, pred_result_o;
    logic [9:0] psel_o;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [7:0] idx;
        logic [1:0] way;
        bit         v;
    } ent_t;
    ent_t mq[$];
    int   m_psel = 512;
    int   m_thr = 0;

    always #5 clk = ~clk;

    wt_dcache_drrip_ctrl #(
        .IDX_W(8), .WAY_W(2), .HITQ_DEPTH(DEPTH), .PSEL_W(10), .BIP_W(5), .LEADER_W(6)
    ) dut (
        .clk_i(clk), .rst_ni(rst_ni), .flush_i(flush_i),
        .hit_req_i(hit_req_i), .hit_idx_i(hit_idx_i), .hit_way_i(hit_way_i),
        .miss_req_i(miss_req_i), .miss_idx_i(miss_idx_i), .srrip_way_i(srrip_way_i),
        .srrip_hit_o(srrip_hit_o), .srrip_hit_idx_o(srrip_hit_idx_o), .srrip_hit_way_o(srrip_hit_way_o),
        .srrip_miss_o(srrip_miss_o), .srrip_miss_idx_o(srrip_miss_idx_o),
        .pred_result_o(pred_result_o), .hit_drop_o(hit_drop_o),
        .policy_o(policy_o), .psel_o(psel_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock of traffic: drive after the falling edge, check mid-cycle, advance the model, wait for the next falling edge.
    task automatic cycle(input bit h, input logic [7:0] hi, input logic [1:0] hw,
                         input bit m, input logic [7:0] mi, input logic [1:0] vw, input bit f);
        bit e_hit, e_drop, pop, push, coll, sl, bl, btype, pol;
        logic [7:0] e_hidx;
        logic [1:0] e_hway;
        int e_pred;
        hit_req_i = h; hit_idx_i = hi; hit_way_i = hw;
        miss_req_i = m; miss_idx_i = mi; srrip_way_i = vw; flush_i = f;
        #1;
        pol    = DUEL && (m_psel >= 512);
        sl     = (mi[5:0] == 6'd0);
        bl     = (mi[5:0] == 6'd63);
        btype  = bl || (!sl && pol);
        e_pred = (DUEL && btype && m_thr != 0) ? 0 : 2;
        e_hit = 0; e_drop = 0; pop = 0; push = 0; e_hidx = hi; e_hway = hw;
        if (!f) begin
            if (mq.size() == 0 && !m) begin
                e_hit = h;
            end else begin
                pop  = (mq.size() > 0) && (!m || !mq[0].v);
                if (!m && mq.size() > 0 && mq[0].v) begin
                    e_hit = 1; e_hidx = mq[0].idx; e_hway = mq[0].way;
                end
                coll   = m && hi == mi && hw == vw;
                push   = h && !coll && (mq.size() < DEPTH || pop);
                e_drop = h && !coll && mq.size() == DEPTH && !pop;
            end
        end
        chk("miss_o", 32'(srrip_miss_o), 32'(m && !f));
        chk("hit_o", 32'(srrip_hit_o), 32'(e_hit));
        chk("drop_o", 32'(hit_drop_o), 32'(e_drop));
        chk("psel_o", 32'(psel_o), 32'(DUEL ? m_psel : 512));
        chk("policy_o", 32'(policy_o), 32'(pol));
        if (e_hit) begin
            chk("hit_idx", 32'(srrip_hit_idx_o), 32'(e_hidx));
            chk("hit_way", 32'(srrip_hit_way_o), 32'(e_hway));
        end
        if (m && !f) begin
            chk("miss_idx", 32'(srrip_miss_idx_o), 32'(mi));
            chk("pred", 32'(pred_result_o), 32'(e_pred));
        end
        if (f) begin
            mq.delete(); m_psel = 512; m_thr = 0;
        end else begin
            if (m)
                foreach (mq[i]) if (mq[i].v && mq[i].idx == mi && mq[i].way == vw) mq[i].v = 0;
            if (pop) void'(mq.pop_front());
            if (push) mq.push_back('{idx: hi, way: hw, v: 1'b1});
            if (m && DUEL) begin
                if (btype) m_thr = (m_thr + 1) % 32;
                if (sl && m_psel < 1023) m_psel++;
                else if (bl && m_psel > 0) m_psel--;
            end
        end
        @(negedge clk);
    endtask

    task automatic idle();
        cycle(0, 8'h00, 2'd0, 0, 8'h00, 2'd0, 0);
    endtask

    function automatic logic [7:0] pick();
        case ($urandom % 4)
            0: return 8'h05;
            1: return 8'h40;
            2: return 8'h3F;
            default: return 8'($urandom);
        endcase
    endfunction

    initial begin
        logic [1:0] wseq [5];
        wseq = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        repeat (3) @(negedge clk);
        chk("rst_psel", 32'(psel_o), 32'd512);
        chk("rst_policy", 32'(policy_o), 32'(DUEL));
        chk("rst_hit", 32'(srrip_hit_o), 32'd0);
        chk("rst_miss", 32'(srrip_miss_o), 32'd0);
        chk("rst_drop", 32'(hit_drop_o), 32'd0);
        rst_ni = 1'b1;

        // Bypass hit
        cycle(1, 8'h12, 2'd1, 0, 8'h00, 2'd0, 0);
        idle();

        // Fill the FIFO behind misses, overflow once, then drain in order
        for (int i = 0; i < 5; i++) cycle(1, 8'h22, wseq[i], 1, 8'h05, 2'd3, 0);
        for (int i = 0; i < 5; i++) idle();

        // Squash a queued hit with a matching victim
        cycle(1, 8'h05, 2'd2, 1, 8'h07, 2'd1, 0);
        cycle(0, 8'h00, 2'd0, 1, 8'h05, 2'd2, 0);
        repeat (3) idle();

        // Flush with three queued entries
        for (int i = 0; i < 3; i++) cycle(1, 8'h30, 2'(i), 1, 8'h41, 2'd3, 0);
        cycle(1, 8'h31, 2'd0, 1, 8'h09, 2'd0, 1);
        repeat (3) idle();

        // PSEL saturation and decrement
        repeat (600) cycle(0, 8'h00, 2'd0, 1, 8'h40, 2'd0, 0);
        chk("psel_sat", 32'(psel_o), DUEL ? 32'd1023 : 32'd512);
        repeat (600) cycle(0, 8'h00, 2'd0, 1, 8'h3F, 2'd0, 0);
        chk("psel_dec", 32'(psel_o), DUEL ? 32'd423 : 32'd512);

        // Throttle sequence from a clean state with PSEL saturated high
        cycle(0, 8'h00, 2'd0, 0, 8'h00, 2'd0, 1);
        repeat (600) cycle(0, 8'h00, 2'd0, 1, 8'h40, 2'd0, 0);
        repeat (33) cycle(0, 8'h00, 2'd0, 1, 8'h05, 2'd1, 0);

        // Random traffic
        for (int n = 0; n < 3000; n++) begin
            cycle($urandom_range(0, 1) == 1, pick(), 2'($urandom),
                  $urandom_range(0, 9) < 4, pick(), 2'($urandom),
                  $urandom_range(0, 99) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/wt_dcache_drrip_ctrl.md
Name: wt_dcache_drrip_ctrl

Overview:
- Policy controller and update sequencer in front of the dcache SRRIP replacement array.
- Owns the single update port of that array. Misses have priority there, so this block buffers hit-promotion updates that would otherwise be lost and issues them in order.
- Selects the insertion RRPV for every refill via DRRIP set dueling: SRRIP vs BRRIP leader sets, a PSEL counter and a BRRIP throttle counter.
- Sits between wt_dcache_mem/miss unit and the replacement array.

Parameters:
- IDX_W, DCACHE_CL_IDX_WIDTH: set index width.
- WAY_W, $clog2(DCACHE_SET_ASSOC) (=2): way index width.
- HITQ_DEPTH, 4: hit-update FIFO entries (power of 2, >=2).
- PSEL_W, 10: policy-select counter width.
- BIP_W, 5: BRRIP throttle width; one long insertion per 2^BIP_W BRRIP insertions.
- LEADER_W, 6: leader index bits (must be <= IDX_W).

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- flush_i  in  1  synchronous cache flush
- hit_req_i  in  1  load/store hit, promote way
- hit_idx_i  in  IDX_W  hit set
- hit_way_i  in  WAY_W  hit way
- miss_req_i  in  1  refill needs victim
- miss_idx_i  in  IDX_W  refill set
- srrip_way_i  in  WAY_W  victim way returned by array (comb, valid with srrip_miss_o)
- srrip_hit_o  out  1  issue hit update
- srrip_hit_idx_o  out  IDX_W
- srrip_hit_way_o  out  WAY_W
- srrip_miss_o  out  1  issue miss update
- srrip_miss_idx_o  out  IDX_W
- pred_result_o  out  2  insertion code: 0=distant(3), 2=long(2)
- hit_drop_o  out  1  hit update discarded this cycle
- policy_o  out  1  follower policy: 0=SRRIP, 1=BRRIP
- psel_o  out  PSEL_W  PSEL value

Behaviour:
- Reset (rst_ni=0, async):
  - FIFO empty; PSEL=2^(PSEL_W-1) (512); throttle=0.
  - srrip_hit_o=srrip_miss_o=hit_drop_o=0; policy_o=1 (PSEL MSB).
- Flush (flush_i=1, sync): applies the reset state next edge. In the flush cycle srrip_hit_o, srrip_miss_o and hit_drop_o are forced 0, and incoming requests are discarded.
- Miss path (combinational, 0 latency):
  - srrip_miss_o=miss_req_i, srrip_miss_idx_o=miss_idx_i.
  - srrip_hit_o=0 in any miss cycle.
- Leader classification on miss_idx_i[LEADER_W-1:0]:
  - all-zero: SRRIP leader.
  - all-one: BRRIP leader.
  - otherwise: follower.
- Insertion code:
  - SRRIP leader, or follower with policy_o=0: pred=2.
  - BRRIP leader, or follower with policy_o=1: pred=2 if throttle==0, else 0.
  - Throttle increments mod 2^BIP_W on each BRRIP-type insertion only.
- PSEL, updated at the edge after a miss:
  - SRRIP-leader miss: +1, saturating at 2^PSEL_W-1.
  - BRRIP-leader miss: -1, saturating at 0.
  - Follower miss: no change.
  - policy_o=PSEL[PSEL_W-1].
- Hit path:
  - Bypass (0 latency) when the FIFO is empty and miss_req_i=0: drive srrip_hit_* directly from hit_*; nothing is enqueued.
  - Drain: when the FIFO is non-empty and miss_req_i=0, issue the head and pop it. A concurrent hit_req_i is pushed. Order is strictly preserved; bypass never overtakes queued entries.
  - When miss_req_i=1: hit_req_i is pushed if the FIFO is not full.
  - If full and no pop occurs that cycle, the hit is dropped and hit_drop_o=1 (combinational, 1 cycle).
  - Full with simultaneous pop and push stays full; no drop.
- Squash: in a miss cycle, every valid FIFO entry with idx==miss_idx_i and way==srrip_way_i is invalidated. Invalid entries at the head are popped without issuing. This prevents promoting a newly inserted line with a stale hit.
- Squash/push collision: an incoming hit in the same cycle that matches the miss idx and victim way is not pushed and does not assert hit_drop_o.
- FIFO pointers are log2(HITQ_DEPTH)+1 bits with wrap-around compare for full/empty.

Optional Feature:
DRRIP_SET_DUEL_EN
- Defined: set dueling, PSEL and throttle as above.
- Undefined:
  - PSEL and throttle logic absent; psel_o tied to 2^(PSEL_W-1), policy_o tied 0.
  - pred_result_o is constant 2 (pure SRRIP).
  - The hit FIFO and squash logic are unchanged.

Test Plan:
- Reset release -> psel_o=512, policy_o=1, srrip_hit_o=srrip_miss_o=hit_drop_o=0.
- hit_req idx=0x12 way=1, FIFO empty, no miss -> srrip_hit_o=1, idx=0x12, way=1 same cycle; FIFO stays empty.
- 5 consecutive cycles of miss (follower idx 0x05) plus hit (ways 0,1,2,3,0) with DEPTH=4 -> 4 entries queued; 5th cycle hit_drop_o=1. Misses then stop -> ways 0,1,2,3 issued on 4 consecutive cycles.
- 600 misses on idx 0x40 (SRRIP leader) -> psel_o saturates at 1023; 600 misses on idx 0x3F -> psel_o ends at 423 (floor 0 not reached).
- PSEL=1023, follower misses from throttle=0 -> pred 2, then 31 x pred 0, 33rd miss pred 2. With macro undefined -> always pred 2.
- Hit idx 5 way 2 queued behind a miss, then a miss idx 5 with srrip_way_i=2 -> entry squashed, never issued, no hit_drop_o.
- flush_i with 3 queued entries -> no srrip_hit_o on the following cycles; psel_o=512, throttle reset.
